block_writer: RTL and testbench
===============================

// Module: block_writer
// PURPOSE
//  Consumes a block base address produced by the allocator and fills that 32-word RAM block with one record.
//  Accepts payload words over a valid/ready stream and writes them to word offsets 1..31.
//  Finally writes header word 0: alloc bit 31 = 1, payload count in [4:0].
//  Sits between the allocator and the single-port ram1024x32; drives its address/data/wren.
// PARAMETERS
//  ADDR_W       10  RAM address width
//  DATA_W       32  RAM word width
//  BLOCK_WORDS  32  words per block, power of 2; payload capacity = BLOCK_WORDS-1
// PORTS
//  clock        in   1       system clock, all logic on posedge
//  resetn       in   1       synchronous, active-low reset
//  start        in   1       begin a record (sampled in IDLE only)
//  base_addr    in   ADDR_W  block base from allocator; low log2(BLOCK_WORDS) bits ignored
//  word_valid   in   1       payload word present
//  word_data    in   DATA_W  payload word
//  word_last    in   1       qualifies final payload word of record
//  word_ready   out  1       block accepts a word this cycle
//  busy         out  1       record in progress (state != IDLE)
//  done         out  1       one-cycle pulse after header written
//  overflow     out  1       record truncated at capacity; sticky until next accepted start
//  ram_address  out  ADDR_W  RAM address
//  ram_clock    out  1       = clock
//  ram_data     out  DATA_W  RAM write data
//  ram_wren     out  1       RAM write enable
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state IDLE; word_ready, busy, done, overflow, ram_wren = 0;
//   ram_address, ram_data, count = 0. No RAM write issued during or after reset.
//  FSM IDLE -> WRITE -> HEADER -> FIN -> IDLE. All outputs except ram_clock registered.
//  IDLE: start=1 -> latch base = {base_addr[9:5],5'b0}, count=0, overflow=0, -> WRITE.
//  WRITE: word_ready=1. Beat = word_valid & word_ready. On beat:
//   ram_address <= {base[9:5], count+1}; ram_data <= word_data; ram_wren <= 1; count++.
//   No beat -> ram_wren <= 0. Address formed by concatenation, never crosses block.
//  Beat with word_last=1 -> HEADER. Beat as 31st word without last -> overflow<=1, -> HEADER.
//   word_ready deasserts the cycle after the terminating beat; later words are not accepted.
//  HEADER: ram_address <= base; ram_data <= {1'b1, 26'b0, count[4:0]}; ram_wren <= 1; -> FIN.
//  FIN: ram_wren <= 0; done <= 1 (one cycle); -> IDLE.
//  Latency: last payload write visible 1 cycle after its beat; header 1 cycle later; done 1 after that.
//  start outside IDLE ignored. word_last without word_valid has no effect.
//  Zero-payload records are not supported; count >= 1 at HEADER.
//  Reset mid-record: abandon, no header write; block keeps alloc bit from allocator (caller frees).
//  ram_q not used; block is write-only.
// STRUCTURE
//  Shared include mem_defs.vh: ADDR_W, DATA_W, BLOCK_WORDS, OFFSET_W=5, ALLOC_BIT=31,
//   COUNT_LSB=0/COUNT_W=5 header fields, FSM state encodings (shared with allocator/free logic).
//  Single module; no sub-module. Est. 150-200 lines.
// TESTING
//  1 resetn=0 two cycles -> all outputs 0, ram_wren never 1; word_ready=0 in IDLE.
//  2 start, base=0x040, words A,B,C (last on C) -> writes 0x041=A, 0x042=B, 0x043=C, then 0x040=0x80000003; done 1 cycle; overflow=0.
//  3 same with word_valid gaps of 2 cycles -> ram_wren=0 in gaps, addresses still 0x041..0x043 contiguous.
//  4 base=0x3E0, 31 words no last -> writes 0x3E1..0x3FF, header 0x3E0=0x8000001F, overflow=1, word_ready=0 after.
//  5 base=0x047 -> treated as 0x040; start pulses while busy -> ignored, one header write only.
//  6 resetn=0 after 2 beats of record at 0x080 -> no write to 0x080, busy=0 next cycle, new start works.

Source files
------------

// File: rtl/block_writer_pkg.sv
// Shared constants, header layout and FSM encoding for the block writer.
// The header helper keeps the word-0 format in one place for allocator/free logic too.
package block_writer_pkg;

    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 32;
    localparam int BLOCK_WORDS = 32;
    localparam int OFFSET_W    = $clog2(BLOCK_WORDS);
    localparam int CAPACITY    = BLOCK_WORDS - 1;
    localparam int ALLOC_BIT   = 31;
    localparam int COUNT_LSB   = 0;
    localparam int COUNT_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_HEADER = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] make_header(input logic [COUNT_W-1:0] count);
        logic [DATA_W-1:0] h;
        h                          = '0;
        h[ALLOC_BIT]               = 1'b1;
        h[COUNT_LSB +: COUNT_W]    = count;
        return h;
    endfunction

endpackage

// File: rtl/block_writer.sv
// Fills one allocator-provided RAM block with a record: payload at offsets 1..N,
// then header word 0 carrying the alloc bit and payload count.
//
//  state  | meaning
//  IDLE   | waiting for start; latches block base
//  WRITE  | accepting payload words into offsets 1..31
//  HEADER | writing header word at block offset 0
//  FIN    | one-cycle done pulse, back to IDLE
module block_writer
    import block_writer_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_clock,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren
);

    localparam int BLOCK_W = ADDR_W - OFFSET_W;

    state_t                state_q, state_nxt;
    logic [BLOCK_W-1:0]    block_q, block_nxt;
    logic [OFFSET_W-1:0]   count_q, count_nxt;
    logic [OFFSET_W-1:0]   count_inc;
    logic                  beat;
    logic                  word_ready_nxt, busy_nxt, done_nxt, overflow_nxt, ram_wren_nxt;
    logic [ADDR_W-1:0]     ram_address_nxt;
    logic [DATA_W-1:0]     ram_data_nxt;

    assign ram_clock = clock;
    assign beat      = word_valid & word_ready;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_nxt       = state_q;
        block_nxt       = block_q;
        count_nxt       = count_q;
        overflow_nxt    = overflow;
        ram_address_nxt = ram_address;
        ram_data_nxt    = ram_data;
        ram_wren_nxt    = 1'b0;
        done_nxt        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    block_nxt    = base_addr[ADDR_W-1:OFFSET_W];
                    count_nxt    = '0;
                    overflow_nxt = 1'b0;
                    state_nxt    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (beat) begin
                    // Concatenated address keeps every payload write inside the block.
                    ram_address_nxt = {block_q, count_inc};
                    ram_data_nxt    = word_data;
                    ram_wren_nxt    = 1'b1;
                    count_nxt       = count_inc;
                    if (word_last) begin
                        state_nxt = ST_HEADER;
                    end else if (count_inc == OFFSET_W'(CAPACITY)) begin
                        overflow_nxt = 1'b1;
                        state_nxt    = ST_HEADER;
                    end
                end
            end
            ST_HEADER: begin
                ram_address_nxt = {block_q, {OFFSET_W{1'b0}}};
                ram_data_nxt    = make_header(count_q);
                ram_wren_nxt    = 1'b1;
                state_nxt       = ST_FIN;
            end
            ST_FIN: begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Handshake/status are registered from the next state so they align with it.
        word_ready_nxt = (state_nxt == ST_WRITE);
        busy_nxt       = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            block_q     <= '0;
            count_q     <= '0;
            word_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            block_q     <= block_nxt;
            count_q     <= count_nxt;
            word_ready  <= word_ready_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            overflow    <= overflow_nxt;
            ram_address <= ram_address_nxt;
            ram_data    <= ram_data_nxt;
            ram_wren    <= ram_wren_nxt;
        end
    end

endmodule

// File: tb/tb_block_writer.sv
// Randomized bench for block_writer: a queue of expected RAM writes derived from
// the record rules is checked against every DUT write, plus literal anchors.
module tb_block_writer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [9:0]  base_addr;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready, busy, done, overflow, ram_clock, ram_wren;
    logic [9:0]  ram_address;
    logic [31:0] ram_data;

    int tests = 0;
    int fails = 0;

    logic [41:0] exp_q[$];
    logic [41:0] obs[$];
    logic [31:0] words[64];
    bit          chk_en  = 1'b0;
    logic        prev_done = 1'b0;

    block_writer dut (
        .clock(clock), .resetn(resetn), .start(start), .base_addr(base_addr),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready), .busy(busy), .done(done), .overflow(overflow),
        .ram_address(ram_address), .ram_clock(ram_clock), .ram_data(ram_data),
        .ram_wren(ram_wren)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every RAM write must be the next one the record rules predict.
    always @(negedge clock) begin
        if (chk_en) begin
            if (ram_wren) begin
                obs.push_back({ram_address, ram_data});
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             ram_address, ram_data);
                end else begin
                    check("ram_write", 64'({ram_address, ram_data}), 64'(exp_q.pop_front()));
                end
            end
            if (done) begin
                check("done_single_cycle", 64'(prev_done), 64'(0));
                check("done_after_header", 64'(exp_q.size()), 64'(0));
            end
        end
        prev_done = done;
    end

    task automatic fill_random(input int k);
        for (int i = 0; i < k; i++) words[i] = $urandom;
    endtask

    task automatic run_record(input logic [9:0] base, input int k, input bit give_last,
                              input int gap_min, input int gap_max, input bit spam);
        logic [9:0] aligned;
        int         n_acc, accepted, gap, t;
        bit         exp_ovf, stop;
        aligned = {base[9:5], 5'b0};
        exp_ovf = !(give_last && k <= 31);
        n_acc   = exp_ovf ? 31 : k;
        for (int i = 0; i < n_acc; i++) exp_q.push_back({aligned + 10'(i + 1), words[i]});
        exp_q.push_back({aligned, 32'h8000_0000 | 32'(n_acc)});
        obs.delete();

        start = 1'b1; base_addr = base;
        @(negedge clock);
        start = 1'b0;
        accepted = 0;
        stop = 1'b0;
        for (int i = 0; i < k && !stop; i++) begin
            gap = $urandom_range(gap_max, gap_min);
            word_valid = 1'b0;
            word_last  = 1'b0;
            repeat (gap) begin
                @(negedge clock);
                if (spam) begin
                    start     = 1'($urandom_range(1, 0));
                    base_addr = 10'($urandom);
                end
            end
            start      = 1'b0;
            word_valid = 1'b1;
            word_data  = words[i];
            word_last  = give_last && (i == k - 1);
            if (!word_ready) stop = 1'b1;
            else begin
                accepted++;
                @(negedge clock);
            end
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
        check("accepted_words", 64'(accepted), 64'(n_acc));
        check("ready_after_term", 64'(word_ready), 64'(0));

        t = 0;
        while (!done && t < 10) begin
            @(negedge clock);
            t++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done after %0d cycles, required a pulse", t);
        end else begin
            check("overflow", 64'(overflow), 64'(exp_ovf));
            check("busy_at_done", 64'(busy), 64'(0));
        end
        repeat (2) @(negedge clock);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; base_addr = '0;
        word_valid = 1'b0; word_data = '0; word_last = 1'b0;

        // Reset held for two cycles: all registered outputs clear.
        @(negedge clock);
        chk_en = 1'b1;
        check("reset_outputs_1", 64'({word_ready, busy, done, overflow, ram_wren, ram_address, ram_data}), 64'(0));
        @(negedge clock);
        check("reset_outputs_2", 64'({word_ready, busy, done, overflow, ram_wren, ram_address, ram_data}), 64'(0));
        resetn = 1'b1;
        @(negedge clock);
        check("idle_not_ready", 64'(word_ready), 64'(0));

        // Three words, last on C.
        words[0] = 32'hAAAA_0001; words[1] = 32'hBBBB_0002; words[2] = 32'hCCCC_0003;
        run_record(10'h040, 3, 1'b1, 0, 0, 1'b0);
        check("t2_first_write", 64'(obs[0]), 64'({10'h041, 32'hAAAA_0001}));
        check("t2_header", 64'(obs[3]), 64'({10'h040, 32'h8000_0003}));

        // Same record with two-cycle gaps between words.
        run_record(10'h040, 3, 1'b1, 2, 2, 1'b0);
        check("t3_third_write", 64'(obs[2]), 64'({10'h043, 32'hCCCC_0003}));
        check("t3_write_count", 64'(obs.size()), 64'(4));

        // Capacity overflow at the top of memory.
        fill_random(33);
        run_record(10'h3E0, 33, 1'b0, 0, 1, 1'b0);
        check("t4_last_payload", 64'(obs[30]), 64'({10'h3FF, words[30]}));
        check("t4_header", 64'(obs[31]), 64'({10'h3E0, 32'h8000_001F}));
        check("t4_overflow_sticky", 64'(overflow), 64'(1));

        // Unaligned base plus start pulses while busy.
        fill_random(5);
        run_record(10'h047, 5, 1'b1, 1, 2, 1'b1);
        check("t5_write_count", 64'(obs.size()), 64'(6));
        check("t5_header", 64'(obs[5]), 64'({10'h040, 32'h8000_0005}));
        check("t5_overflow_cleared", 64'(overflow), 64'(0));

        // Reset in the middle of a record at 0x080.
        fill_random(8);
        exp_q.push_back({10'h081, words[0]});
        exp_q.push_back({10'h082, words[1]});
        start = 1'b1; base_addr = 10'h080;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            word_valid = 1'b1; word_data = words[i];
            @(negedge clock);
        end
        word_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clock);
        check("t6_busy_after_reset", 64'(busy), 64'(0));
        check("t6_outputs_after_reset", 64'({word_ready, done, ram_wren}), 64'(0));
        check("t6_payload_written", 64'(exp_q.size()), 64'(0));
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        fill_random(4);
        run_record(10'h080, 4, 1'b1, 0, 1, 1'b0);
        check("t6_restart_header", 64'(obs[4]), 64'({10'h080, 32'h8000_0004}));

        // Randomized records.
        for (int r = 0; r < 25; r++) begin
            int  k;
            bit  gl;
            k  = $urandom_range(35, 1);
            gl = ($urandom_range(3, 0) != 0);
            if (!gl && k < 32) k = 32 + $urandom_range(2, 0);
            fill_random(k);
            run_record(10'($urandom), k, gl, 0, 3, 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
